// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the K=3, rate-1/2 (7,5 octal) Viterbi datapath.
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam logic [2:0] GEN_C0 = 3'o7;
  localparam logic [2:0] GEN_C1 = 3'o5;

  typedef logic [1:0] state_t;
  typedef logic [1:0] sym_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Encoder output {c1,c0} when input u is shifted into state s={b1,b0}.
  function automatic sym_t expected_sym(input logic u, input state_t s);
    logic [2:0] sreg;
    sreg = {u, s};
    return {^(sreg & GEN_C1), ^(sreg & GEN_C0)};
  endfunction

endpackage

// File: rtl/acs_butterfly.sv
// Add-compare-select for one next state: two saturating candidates, strict compare, tie to even predecessor.
module acs_butterfly
  import viterbi_pkg::*;
#(
  parameter int     PM_W = 4,
  parameter state_t NEXT = 2'd0
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      symbol,
  output logic [PM_W-1:0] pm_new,
  output logic            decision
);

  localparam logic [PM_W-1:0] MAX = '1;
  localparam state_t PA = {NEXT[0], 1'b0};
  localparam state_t PB = {NEXT[0], 1'b1};
  localparam logic   U  = NEXT[1];

  function automatic logic [1:0] hamming(input sym_t a, input sym_t b);
    sym_t d;
    d = a ^ b;
    return {d[1] & d[0], d[1] ^ d[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return sum[PM_W] ? MAX : sum[PM_W-1:0];
  endfunction

  logic [PM_W-1:0] cand_a, cand_b;

  always_comb begin
    cand_a   = sat_add(pm_a, hamming(symbol, expected_sym(U, PA)));
    cand_b   = sat_add(pm_b, hamming(symbol, expected_sym(U, PB)));
    decision = (cand_b < cand_a);
    pm_new   = decision ? cand_b : cand_a;
  end

endmodule

// File: rtl/acs_unit.sv
// Viterbi ACS stage with frame FSM, clipped metric outputs and symbol counter.
// Define ACS_NORM_EN to renormalise metrics so the minimum is always 0.
module acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [1:0]       i_symbol,
  input  logic             i_last,
  output logic             o_valid,
  output logic [1:0]       o_path_metric_0,
  output logic [1:0]       o_path_metric_1,
  output logic [1:0]       o_path_metric_2,
  output logic [1:0]       o_path_metric_3,
  output logic [3:0]       o_decision,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_sym_count
);

  localparam logic [PM_W-1:0]  MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fsm_t                  fsm_p1;
  logic [PM_W-1:0]       pm_p1   [NUM_STATES];
  logic [PM_W-1:0]       pred_p0 [NUM_STATES];
  logic [PM_W-1:0]       acs_p0  [NUM_STATES];
  logic [PM_W-1:0]       norm_p0 [NUM_STATES];
  logic [NUM_STATES-1:0] dec_p0;

  function automatic logic [1:0] clip2(input logic [PM_W-1:0] pm);
    return (pm > PM_W'(3)) ? 2'd3 : pm[1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

  // Stage p0: predecessor select, ACS, optional normalisation
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      if (fsm_p1 == IDLE) pred_p0[i] = (i == 0) ? '0 : MAX;
      else                pred_p0[i] = pm_p1[i];
    end
  end

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    acs_butterfly #(
      .PM_W (PM_W),
      .NEXT (state_t'(n))
    ) u_bfly (
      .pm_a     (pred_p0[2*(n%2)]),
      .pm_b     (pred_p0[2*(n%2)+1]),
      .symbol   (i_symbol),
      .pm_new   (acs_p0[n]),
      .decision (dec_p0[n])
    );
  end

`ifdef ACS_NORM_EN
  logic [PM_W-1:0] min_p0;

  always_comb begin
    min_p0 = acs_p0[0];
    for (int i = 1; i < NUM_STATES; i++)
      if (acs_p0[i] < min_p0) min_p0 = acs_p0[i];
    for (int i = 0; i < NUM_STATES; i++)
      norm_p0[i] = acs_p0[i] - min_p0;
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++)
      norm_p0[i] = acs_p0[i];
  end
`endif

  // Stage p1: registered metrics, decisions and frame control
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_p1          <= IDLE;
      pm_p1[0]        <= '0;
      for (int i = 1; i < NUM_STATES; i++) pm_p1[i] <= MAX;
      o_valid         <= 1'b0;
      o_frame_done    <= 1'b0;
      o_decision      <= '0;
      o_sym_count     <= '0;
      o_path_metric_0 <= 2'd0;
      o_path_metric_1 <= 2'd3;
      o_path_metric_2 <= 2'd3;
      o_path_metric_3 <= 2'd3;
    end else begin
      o_valid      <= i_valid;
      o_frame_done <= i_valid & i_last;
      if (i_valid) begin
        fsm_p1          <= i_last ? IDLE : RUN;
        for (int i = 0; i < NUM_STATES; i++) pm_p1[i] <= norm_p0[i];
        o_decision      <= dec_p0;
        o_path_metric_0 <= clip2(norm_p0[0]);
        o_path_metric_1 <= clip2(norm_p0[1]);
        o_path_metric_2 <= clip2(norm_p0[2]);
        o_path_metric_3 <= clip2(norm_p0[3]);
        o_sym_count     <= (fsm_p1 == IDLE) ? CNT_W'(1) : sat_inc(o_sym_count);
      end
    end
  end

endmodule

// File: tb/tb_acs_unit.sv
// Scoreboard bench for acs_unit: behavioural trellis model feeds an expectation queue.
module tb_acs_unit;

  localparam int MAX  = 15;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [1:0] sym = 2'd0;

  logic       o_valid, o_frame_done;
  logic [1:0] o_pm0, o_pm1, o_pm2, o_pm3;
  logic [3:0] o_decision;
  logic [7:0] o_sym_count;

  acs_unit #(.PM_W(4), .CNT_W(8)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (valid),
    .i_symbol        (sym),
    .i_last          (last),
    .o_valid         (o_valid),
    .o_path_metric_0 (o_pm0),
    .o_path_metric_1 (o_pm1),
    .o_path_metric_2 (o_pm2),
    .o_path_metric_3 (o_pm3),
    .o_decision      (o_decision),
    .o_frame_done    (o_frame_done),
    .o_sym_count     (o_sym_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][1:0] pmc;
    logic [3:0]      dec;
    logic            done;
    logic [7:0]      cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   tests = 0;
  int   fails = 0;
  int   m_pm[4];
  bit   m_run;
  int   m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_reset();
    m_pm     = '{0, MAX, MAX, MAX};
    m_run    = 1'b0;
    m_cnt    = 0;
    last_exp = '{pmc: {2'd3, 2'd3, 2'd3, 2'd0}, dec: 4'd0, done: 1'b0, cnt: 8'd0};
    sb_q.delete();
  endtask

  // Forward trellis walk over every (state, input) edge; strict < keeps the even predecessor on ties.
  task automatic model_step(input logic [1:0] s_in, input logic l);
    int pred[4];
    int nxt[4];
    logic [3:0] d;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      pred[i] = m_run ? m_pm[i] : ((i == 0) ? 0 : MAX);
      nxt[i]  = 1 << 30;
    end
    d = 4'd0;
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        int nn, c0, c1, bm, cand;
        nn   = u * 2 + s / 2;
        c0   = u ^ (s / 2) ^ (s % 2);
        c1   = u ^ (s % 2);
        bm   = ((int'(s_in[0]) != c0) ? 1 : 0) + ((int'(s_in[1]) != c1) ? 1 : 0);
        cand = pred[s] + bm;
        if (cand > MAX) cand = MAX;
        if (cand < nxt[nn]) begin
          nxt[nn] = cand;
          d[nn]   = s[0];
        end
      end
    end
`ifdef ACS_NORM_EN
    begin
      int mn;
      mn = nxt[0];
      for (int i = 1; i < 4; i++) if (nxt[i] < mn) mn = nxt[i];
      for (int i = 0; i < 4; i++) nxt[i] -= mn;
    end
`endif
    m_pm  = nxt;
    m_cnt = m_run ? ((m_cnt < CMAX) ? m_cnt + 1 : CMAX) : 1;
    m_run = !l;
    for (int i = 0; i < 4; i++) e.pmc[i] = 2'(clip(nxt[i]));
    e.dec  = d;
    e.done = l;
    e.cnt  = 8'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic compare_fields(input exp_t e);
    check_val("pm0", 32'(o_pm0), 32'(e.pmc[0]));
    check_val("pm1", 32'(o_pm1), 32'(e.pmc[1]));
    check_val("pm2", 32'(o_pm2), 32'(e.pmc[2]));
    check_val("pm3", 32'(o_pm3), 32'(e.pmc[3]));
    check_val("decision", 32'(o_decision), 32'(e.dec));
    check_val("frame_done", 32'(o_frame_done), 32'(e.done));
    check_val("sym_count", 32'(o_sym_count), 32'(e.cnt));
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic l);
    @(negedge clk);
    valid = v;
    sym   = s;
    last  = l;
    if (v) model_step(s, l);
    @(posedge clk);
    #1;
    check_val("o_valid", 32'(o_valid), 32'(v));
    if (o_valid) begin
      check_val("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) last_exp = sb_q.pop_front();
    end else begin
      last_exp.done = 1'b0;
    end
    compare_fields(last_exp);
`ifdef ACS_NORM_EN
    if (o_valid) begin
      int mn;
      mn = int'(o_pm0);
      if (int'(o_pm1) < mn) mn = int'(o_pm1);
      if (int'(o_pm2) < mn) mn = int'(o_pm2);
      if (int'(o_pm3) < mn) mn = int'(o_pm3);
      check_val("norm_min", 32'(mn), 32'd0);
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_valid", 32'(o_valid), 32'd0);
    check_val("rst_pm0", 32'(o_pm0), 32'd0);
    check_val("rst_pm1", 32'(o_pm1), 32'd3);
    check_val("rst_pm2", 32'(o_pm2), 32'd3);
    check_val("rst_pm3", 32'(o_pm3), 32'd3);
    check_val("rst_dec", 32'(o_decision), 32'd0);
    check_val("rst_done", 32'(o_frame_done), 32'd0);
    check_val("rst_cnt", 32'(o_sym_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_first_00();
    check_val("first_pm0", 32'(o_pm0), 32'd0);
    check_val("first_pm1", 32'(o_pm1), 32'd3);
    check_val("first_pm2", 32'(o_pm2), 32'd2);
    check_val("first_pm3", 32'(o_pm3), 32'd3);
    check_val("first_dec", 32'(o_decision), 32'd0);
    check_val("first_cnt", 32'(o_sym_count), 32'd1);
  endtask

  initial begin
    model_reset();
    do_reset();

    // First symbol 00 from IDLE
    step(1'b1, 2'b00, 1'b0);
    check_first_00();

    // Error-free all-zero frame of four symbols
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b00, (i == 3));
      check_val("zero_pm0", 32'(o_pm0), 32'd0);
    end
    check_val("zero_cnt", 32'(o_sym_count), 32'd4);
    check_val("zero_done", 32'(o_frame_done), 32'd1);
    step(1'b0, 2'b00, 1'b0);

    // Encoder output {c1,c0} for input bits 1,0,0 from state 0
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b1);
    check_val("enc_pm0", 32'(o_pm0), 32'd0);

    // Single-symbol frame leaves the FSM in IDLE
    step(1'b1, 2'b11, 1'b1);
    check_val("single_done", 32'(o_frame_done), 32'd1);
    check_val("single_cnt", 32'(o_sym_count), 32'd1);
    step(1'b1, 2'b00, 1'b0);
    check_first_00();

    // Gaps inside a running frame
    step(1'b0, 2'b11, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b0, 2'b01, 1'b1);
    step(1'b0, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b1);

    // Reset abandons a frame after two symbols
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    do_reset();
    step(1'b1, 2'b00, 1'b0);
    check_first_00();
    step(1'b1, 2'b00, 1'b1);

    // Random frame with sporadic gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) step(1'b0, 2'($urandom_range(0, 3)), 1'b0);
      step(1'b1, 2'($urandom_range(0, 3)), (i == 299));
    end

    // Long all-11 frame: metric saturation and counter saturation
    for (int i = 0; i < 300; i++) step(1'b1, 2'b11, (i == 299));
    check_val("sat_cnt", 32'(o_sym_count), 32'd255);
`ifndef ACS_NORM_EN
    check_val("sat_pm0", 32'(o_pm0), 32'd3);
    check_val("sat_pm1", 32'(o_pm1), 32'd3);
`endif
    step(1'b0, 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
